fifo_width_conv: RTL and testbench

FIFO_WIDTH_CONV -- requirements
Module: fifo_width_conv

---
 rtl/fifo_conv_pkg.sv | 13 +
 rtl/fifo_conv_ctrl.sv | 71 +++++++
 rtl/fifo_width_conv.sv | 72 +++++++
 tb/tb_fifo_width_conv.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/fifo_conv_pkg.sv
// Shared types and helpers for the width-converting FIFO (fifo_width_conv).
package fifo_conv_pkg;

    typedef enum logic {
        LsbFirst = 1'b0,
        MsbFirst = 1'b1
    } slice_order_e;

    function automatic int unsigned free_slots(input int unsigned depth, input int unsigned used);
        return depth - used;
    endfunction

endpackage

// File: rtl/fifo_conv_ctrl.sv
// Pointer, occupancy and status control for fifo_width_conv.
// Sticky overflow/underflow flags exist only when FIFO_WIDTH_CONV_ERR_FLAGS_EN is defined.
module fifo_conv_ctrl
    import fifo_conv_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned RATIO      = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr,
    input  logic                  rd,
    output logic                  w_en,
    output logic                  r_en,
    output logic [ADDR_WIDTH-1:0] w_addr,
    output logic [ADDR_WIDTH-1:0] r_addr,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  full,
    output logic                  empty,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] PTR_STEP = RATIO[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] PTR_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};

    logic [ADDR_WIDTH:0] w_ptr;
    logic [ADDR_WIDTH:0] r_ptr;

    // Extra pointer bit disambiguates full from empty; the subtraction wraps naturally.
    assign count  = w_ptr - r_ptr;
    assign full   = free_slots(DEPTH, 32'(count)) < RATIO;
    assign empty  = (count == '0);
    assign w_en   = wr & ~full;
    assign r_en   = rd & ~empty;
    assign w_addr = w_ptr[ADDR_WIDTH-1:0];
    assign r_addr = r_ptr[ADDR_WIDTH-1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w_ptr <= '0;
            r_ptr <= '0;
        end else begin
            if (w_en) w_ptr <= w_ptr + PTR_STEP;
            if (r_en) r_ptr <= r_ptr + PTR_ONE;
        end
    end

`ifdef FIFO_WIDTH_CONV_ERR_FLAGS_EN
    logic overflow_q;
    logic underflow_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_q | (wr & full);
            underflow_q <= underflow_q | (rd & empty);
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`else
    assign overflow  = 1'b0;
    assign underflow = 1'b0;
`endif

endmodule

// File: rtl/fifo_width_conv.sv
// FIFO taking RATIO narrow words per write and returning one per read (first-word-fall-through).
// Optional sticky error flags: define FIFO_WIDTH_CONV_ERR_FLAGS_EN.
module fifo_width_conv
    import fifo_conv_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned RATIO      = 2,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter bit          MSB_FIRST  = 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        wr,
    input  logic [RATIO*DATA_WIDTH-1:0] w_data,
    input  logic                        rd,
    output logic [DATA_WIDTH-1:0]       r_data,
    output logic                        full,
    output logic                        empty,
    output logic [ADDR_WIDTH:0]         count,
    output logic                        overflow,
    output logic                        underflow
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
    localparam slice_order_e ORDER = MSB_FIRST ? MsbFirst : LsbFirst;

    logic                  w_en;
    logic                  r_en;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] slices [RATIO];
    logic [DATA_WIDTH-1:0] mem    [DEPTH];

    fifo_conv_ctrl #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .RATIO     (RATIO)
    ) u_ctrl (
        .clk      (clk),
        .reset    (reset),
        .wr       (wr),
        .rd       (rd),
        .w_en     (w_en),
        .r_en     (r_en),
        .w_addr   (w_addr),
        .r_addr   (r_addr),
        .count    (count),
        .full     (full),
        .empty    (empty),
        .overflow (overflow),
        .underflow(underflow)
    );

    // slices[i] is the i-th narrow word to be read out of this wide write.
    always_comb begin
        for (int i = 0; i < RATIO; i++) begin
            if (ORDER == MsbFirst) slices[i] = w_data[(RATIO-1-i)*DATA_WIDTH +: DATA_WIDTH];
            else                   slices[i] = w_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // w_addr is always RATIO-aligned, so w_addr + i never wraps past the array end.
    always_ff @(posedge clk) begin
        if (w_en) begin
            for (int i = 0; i < RATIO; i++) begin
                mem[w_addr + ADDR_WIDTH'(i)] <= slices[i];
            end
        end
    end

    assign r_data = mem[r_addr];

endmodule

// File: tb/tb_fifo_width_conv.sv
// Directed, scoreboard-checked bench for fifo_width_conv (DATA_WIDTH=8, RATIO=2, ADDR_WIDTH=4).
module tb_fifo_width_conv;

    localparam int DEPTH = 16;
    localparam int RATIO = 2;
`ifdef FIFO_WIDTH_CONV_ERR_FLAGS_EN
    localparam bit FLAGS = 1'b1;
`else
    localparam bit FLAGS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        wr = 1'b0;
    logic        rd = 1'b0;
    logic [15:0] w_data = '0;
    logic [7:0]  r_data;
    logic        full, empty, overflow, underflow;
    logic [4:0]  count;

    logic        wr1 = 1'b0;
    logic        rd1 = 1'b0;
    logic [15:0] w_data1 = '0;
    logic [7:0]  r_data1;
    logic        full1, empty1, overflow1, underflow1;
    logic [4:0]  count1;

    int errors = 0;
    int checks = 0;

    logic [7:0] sb[$];
    int         mcount = 0;
    bit         mover = 1'b0;
    bit         munder = 1'b0;

    always #5 clk = ~clk;

    fifo_width_conv #(
        .DATA_WIDTH(8), .RATIO(2), .ADDR_WIDTH(4), .MSB_FIRST(1)
    ) dut (
        .clk(clk), .reset(reset), .wr(wr), .w_data(w_data), .rd(rd), .r_data(r_data),
        .full(full), .empty(empty), .count(count), .overflow(overflow), .underflow(underflow)
    );

    fifo_width_conv #(
        .DATA_WIDTH(8), .RATIO(2), .ADDR_WIDTH(4), .MSB_FIRST(0)
    ) dut_lsb (
        .clk(clk), .reset(reset), .wr(wr1), .w_data(w_data1), .rd(rd1), .r_data(r_data1),
        .full(full1), .empty(empty1), .count(count1), .overflow(overflow1),
        .underflow(underflow1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_status(input string tag);
        chk({tag, "/count"}, 32'(count), 32'(mcount));
        chk({tag, "/full"}, 32'(full), 32'(mcount > DEPTH - RATIO));
        chk({tag, "/empty"}, 32'(empty), 32'(mcount == 0));
        chk({tag, "/overflow"}, 32'(overflow), 32'(mover));
        chk({tag, "/underflow"}, 32'(underflow), 32'(munder));
    endtask

    // One cycle on the MSB-first DUT; acceptance judged from the model's pre-edge state.
    task automatic op(input bit w, input logic [15:0] d, input bit r, input string tag);
        bit w_ok;
        bit r_ok;
        w_ok = w && (mcount <= DEPTH - RATIO);
        r_ok = r && (mcount != 0);
        if (r_ok) chk({tag, "/r_data"}, 32'(r_data), 32'(sb[0]));
        wr = w;
        w_data = d;
        rd = r;
        tick();
        wr = 1'b0;
        rd = 1'b0;
        if (r_ok) void'(sb.pop_front());
        if (w_ok) begin
            sb.push_back(d[15:8]);
            sb.push_back(d[7:0]);
        end
        mcount = mcount + (w_ok ? RATIO : 0) - (r_ok ? 1 : 0);
        if (w && !w_ok && FLAGS) mover = 1'b1;
        if (r && !r_ok && FLAGS) munder = 1'b1;
        chk_status(tag);
    endtask

    initial begin
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        chk_status("reset");
        chk("reset/lsb_empty", 32'(empty1), 32'd1);

        // Single write then two reads, MSB slice first.
        op(1'b1, 16'hA1B2, 1'b0, "req030_wr");
        chk("req030/head", 32'(r_data), 32'h0A1);
        op(1'b0, 16'h0, 1'b1, "req030_rd0");
        chk("req030/second", 32'(r_data), 32'h0B2);
        op(1'b0, 16'h0, 1'b1, "req030_rd1");

        // LSB-first instance.
        wr1 = 1'b1;
        w_data1 = 16'hA1B2;
        tick();
        wr1 = 1'b0;
        chk("req031/count", 32'(count1), 32'd2);
        chk("req031/first", 32'(r_data1), 32'h0B2);
        rd1 = 1'b1;
        tick();
        chk("req031/second", 32'(r_data1), 32'h0A1);
        tick();
        rd1 = 1'b0;
        chk("req031/empty", 32'(empty1), 32'd1);

        // Fill to full, drop a ninth write, drain.
        for (int i = 1; i <= 8; i++) op(1'b1, {8'(i), 8'(i - 1)}, 1'b0, "req032_fill");
        chk("req032/full", 32'(full), 32'd1);
        chk("req032/count16", 32'(count), 32'd16);
        op(1'b1, 16'hFFFF, 1'b0, "req032_drop");
        chk("req032/overflow", 32'(overflow), 32'(FLAGS));
        for (int i = 0; i < 16; i++) op(1'b0, 16'h0, 1'b1, "req032_drain");

        // count=15: simultaneous wr+rd drops the write, accepts the read.
        for (int i = 0; i < 8; i++) op(1'b1, 16'h3000 + 16'(i), 1'b0, "req033_fill");
        op(1'b0, 16'h0, 1'b1, "req033_rd");
        chk("req033/full15", 32'(full), 32'd1);
        op(1'b1, 16'hDEAD, 1'b1, "req033_both");
        chk("req033/count14", 32'(count), 32'd14);
        chk("req033/notfull", 32'(full), 32'd0);
        for (int i = 0; i < 14; i++) op(1'b0, 16'h0, 1'b1, "req033_drain");

        // Interleaved write/read/read across pointer wrap.
        for (int k = 0; k < 40; k++) begin
            if (k % 3 == 0) op(1'b1, 16'($urandom), 1'b0, "req034_wr");
            else            op(1'b0, 16'h0, 1'b1, "req034_rd");
        end
        while (mcount != 0) op(1'b0, 16'h0, 1'b1, "req034_drain");

        // Asynchronous reset mid-stream.
        for (int i = 0; i < 3; i++) op(1'b1, 16'h5500 + 16'(i), 1'b0, "req035_wr");
        reset = 1'b1;
        #2;
        chk("req035/async_empty", 32'(empty), 32'd1);
        chk("req035/async_count", 32'(count), 32'd0);
        tick();
        reset = 1'b0;
        sb.delete();
        mcount = 0;
        mover = 1'b0;
        munder = 1'b0;
        chk_status("req035_post");
        op(1'b0, 16'h0, 1'b1, "req035_underflow");
        chk("req035/underflow", 32'(underflow), 32'(FLAGS));
        op(1'b1, 16'hC3D4, 1'b0, "req035_wr0");
        chk("req035/head", 32'(r_data), 32'h0C3);
        op(1'b0, 16'h0, 1'b1, "req035_rd0");
        op(1'b0, 16'h0, 1'b1, "req035_rd1");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
